// File: rtl/rx4_word.sv
// rx4_word: 8N1 UART receiver that packs four bytes (LSB first) into a 32-bit word.
// Optional idle timeout for partial words is enabled by defining RX4_TIMEOUT_EN.
`default_nettype none

module rx4_word #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_CLKS = 2080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [31:0] dout,
    output logic        valid,
    output logic        frame_err
);

    localparam int                c_TW      = $clog2(CLKS_PER_BIT);
    localparam logic [c_TW-1:0]   c_HALF_M1 = c_TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_TW-1:0]   c_FULL_M1 = c_TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_STOP     = 3'd3,
        S_ERR_WAIT = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sync1;
    logic              r_sync2;
    logic              w_din_s;
    logic [c_TW-1:0]   r_timer;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_word;
    logic [31:0]       r_dout;
    logic              r_valid;
    logic              r_ferr;
    logic              w_bit_tick;
    logic              w_accept;
    logic              w_ferr;
    logic              w_restart;
    logic              w_timeout;

    assign w_din_s   = r_sync2;
    assign dout      = r_dout;
    assign valid     = r_valid;
    assign frame_err = r_ferr;

    always_comb begin
        w_state_nxt = r_state;
        w_bit_tick  = 1'b0;
        w_accept    = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_din_s) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_timer == c_HALF_M1) w_state_nxt = w_din_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (r_timer == c_FULL_M1) begin
                    w_bit_tick = 1'b1;
                    if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_timer == c_FULL_M1) begin
                    if (w_din_s) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_ERR_WAIT;
                    end
                end
            end
            S_ERR_WAIT: begin
                // Hold off until the line returns high so a break cannot retrigger.
                if (w_din_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_restart = (w_state_nxt != r_state) || w_bit_tick;
    end

`ifdef RX4_TIMEOUT_EN
    localparam int              c_IW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_IW-1:0] c_TIMEOUT  = c_IW'(TIMEOUT_CLKS);
    logic [c_IW-1:0]            r_idle_cnt;
    logic                       w_idle_run;

    assign w_idle_run = (r_state == S_IDLE) && (r_byte_cnt != 2'd0);
    assign w_timeout  = w_idle_run && (r_idle_cnt == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst || !w_idle_run || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + c_IW'(1);
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CLKS;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_byte_cnt <= 2'd0;
            r_word     <= 24'h0;
            r_dout     <= 32'h0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_timer <= w_restart ? '0 : r_timer + c_TW'(1);
            r_valid <= 1'b0;
            r_ferr  <= w_ferr;

            if (r_state == S_START) r_bit_idx <= 3'd0;
            if (w_bit_tick) begin
                r_shift   <= {w_din_s, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                    2'd0: r_word[7:0]   <= r_shift;
                    2'd1: r_word[15:8]  <= r_shift;
                    2'd2: r_word[23:16] <= r_shift;
                    default: begin
                        r_dout  <= {r_shift, r_word};
                        r_valid <= 1'b1;
                        r_word  <= 24'h0;
                    end
                endcase
            end

            if (w_ferr || w_timeout) begin
                r_byte_cnt <= 2'd0;
                r_word     <= 24'h0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rx4_word.sv
// tb_rx4_word: directed scoreboard bench for rx4_word at 16 clocks per bit.
`default_nettype none

module tb_rx4_word;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b1;
    logic [31:0] dout;
    logic        valid;
    logic        frame_err;

    int          errors = 0;
    int          checks = 0;
    int          vcnt   = 0;
    int          fcnt   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    logic [31:0] t6_exp;
    bit          prev_valid = 1'b0;

    rx4_word #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(320)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .dout     (dout),
        .valid    (valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every valid pulse pops one expected word.
    always @(negedge clk) begin
        if (valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid observed dout=%h expected=no pulse", dout);
            end
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                checks++;
                assert (dout === exp_w) else begin
                    errors++;
                    $error("FAIL word observed=%h expected=%h", dout, exp_w);
                end
            end
            checks++;
            assert (prev_valid == 1'b0) else begin
                errors++;
                $error("FAIL valid_width observed=2+ cycles expected=1");
            end
            checks++;
            assert (frame_err === 1'b0) else begin
                errors++;
                $error("FAIL valid_and_ferr observed=%b expected=0", frame_err);
            end
            vcnt++;
        end
        if (frame_err) fcnt++;
        prev_valid = valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        din = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            hold(CPB);
        end
        din = stop;
        hold(CPB);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        hold(5);
        chk("reset_dout", dout, 32'h0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        hold(20);

        // Basic word
        exp_q.push_back(32'h12345678);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        drain("t1_drain");
        hold(20);
        chk("t1_ferr", 32'(fcnt), 32'd0);

        // Start-bit glitch, then a good word proves byte_cnt stayed 0
        din = 1'b0;
        hold(6);
        din = 1'b1;
        hold(60);
        chk("t2_no_valid", 32'(vcnt), 32'd1);
        chk("t2_no_ferr", 32'(fcnt), 32'd0);
        exp_q.push_back(32'hCAFEF00D);
        send_word(32'hCAFEF00D);
        drain("t2_drain");
        hold(20);

        // Frame error on second byte, long break, then recovery
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b0);
        hold(50);
        chk("t3_ferr_once", 32'(fcnt), 32'd1);
        chk("t3_dout_held", dout, 32'hCAFEF00D);
        hold(50);
        chk("t3_no_retrigger", 32'(fcnt), 32'd1);
        din = 1'b1;
        hold(2 * CPB);
        exp_q.push_back(32'hDEADBEEF);
        send_word(32'hDEADBEEF);
        drain("t3_drain");
        hold(20);
        chk("t3_ferr_total", 32'(fcnt), 32'd1);

        // Back-to-back words, no idle between stop and next start
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'hFFFFFFFF);
        send_word(32'h04030201);
        send_word(32'hFFFFFFFF);
        drain("t4_drain");
        hold(20);
        chk("t4_dout", dout, 32'hFFFFFFFF);

        // Reset in the middle of the third byte
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        din = 1'b0;
        hold(CPB);
        for (int i = 0; i < 4; i++) begin
            din = 1'b1;
            hold(CPB);
        end
        rst = 1'b1;
        din = 1'b1;
        hold(1);
        rst = 1'b0;
        hold(1);
        chk("t5_dout_cleared", dout, 32'h0);
        chk("t5_valid_low", 32'(valid), 32'd0);
        hold(40);
        exp_q.push_back(32'hAABBCCDD);
        send_word(32'hAABBCCDD);
        drain("t5_drain");
        hold(20);
        chk("t5_dout", dout, 32'hAABBCCDD);

        // Partial word followed by a long idle gap
`ifdef RX4_TIMEOUT_EN
        t6_exp = 32'h44332211;
`else
        t6_exp = 32'h22118899;
`endif
        exp_q.push_back(t6_exp);
        send_byte(8'h99, 1'b1);
        send_byte(8'h88, 1'b1);
        hold(400);
        send_word(32'h44332211);
        drain("t6_drain");
        hold(40);
        chk("t6_dout", dout, t6_exp);

        chk("total_valid", 32'(vcnt), 32'd7);
        chk("total_ferr", 32'(fcnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rx4_word.md
# rx4_word

- Receive side of the 32-bit word link.
- Deserialises 8N1 UART bytes from a serial input and assembles four consecutive bytes, least-significant byte first, into one 32-bit word.
- Presents the word with a single-cycle valid strobe.
- Pairs with the word transmitter, which sends words LSB-first as four bytes. It sits between the host-facing serial pin and the attack-control logic.

## Interface

Parameters:
- CLKS_PER_BIT, 104: clock cycles per UART bit; must be ≥ 4.
- TIMEOUT_CLKS, 2080: idle cycles after which a partial word is discarded. Used only with RX4_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- din  in  1  asynchronous serial input; idles high.
- dout  out  32  last completed word; reset 32'h0.
- valid  out  1  one-cycle pulse when dout is updated; reset 0.
- frame_err  out  1  one-cycle pulse on a bad stop bit; reset 0.

## Operation

Input conditioning:
- din passes through a 2-flop synchroniser (reset value 1).
- All logic uses the synchronised signal, din_s.

State machine:
- IDLE: when din_s = 0, load the bit timer and go to START.
- START: after CLKS_PER_BIT/2 cycles (integer divide), sample din_s.
  - 0: go to DATA with bit index 0.
  - 1: glitch; return to IDLE with no output.
- DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After bit 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample din_s.
  - 1: the byte is accepted. Go to IDLE, so the next start edge can arrive within half a bit.
  - 0: pulse frame_err, discard the byte, clear byte_cnt to 0, and go to ERR_WAIT.
- ERR_WAIT: stay until din_s = 1, then go to IDLE. This prevents a break condition from retriggering the receiver.

Word assembly:
- A 2-bit byte_cnt selects the lane. Byte k is written to word[8k+7:8k].
- byte_cnt wraps 3 → 0 on the 4th accepted byte.
- On that 4th byte, dout is loaded with the complete word and valid pulses. dout holds until the next complete word.
- A frame error discards any partial word; dout is unchanged.

Reset:
- rst at any time returns the FSM to IDLE and clears byte_cnt, the partial word and the synchroniser.
- dout is cleared to 0, and valid and frame_err are driven 0.
- No pulse is issued for an interrupted word.

## Timing

- Synchroniser latency is 2 cycles from a din edge to din_s.
- IDLE→START happens on the first cycle din_s is seen low.
- Sample points, counted from START entry:
  - start bit: CLKS_PER_BIT/2
  - data bit i: CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT
  - stop bit: CLKS_PER_BIT/2 + 9·CLKS_PER_BIT
- valid and frame_err are registered and assert the cycle after the stop-bit sample.
- dout changes in the same cycle that valid is high.
- valid and frame_err are never high together, and each is high for exactly one cycle.
- Back-to-back bytes with no idle between the stop bit and the next start bit are received without loss.
- The bit timer restarts on every state entry. There is no fractional-bit accumulation; tolerance is ±4% baud mismatch.

## Configuration

RX4_TIMEOUT_EN:
- Defined:
  - An idle counter runs while the FSM is in IDLE and byte_cnt ≠ 0.
  - It clears on entry to START.
  - When it reaches TIMEOUT_CLKS, byte_cnt and the partial word are cleared silently: no valid, no frame_err.
  - The counter width is $clog2(TIMEOUT_CLKS+1).
- Undefined:
  - The counter is absent.
  - A partial word is held indefinitely and completed by later bytes.
  - TIMEOUT_CLKS is ignored.

## Test plan

All cases use CLKS_PER_BIT=16.
- Bytes 0x78, 0x56, 0x34, 0x12 → one valid pulse, dout=32'h12345678, frame_err never asserted.
- din low for 6 cycles, then high → no state beyond START; byte_cnt stays 0; no pulses. A following 4-byte word still decodes correctly.
- Second byte sent with stop bit 0, din held low 100 cycles, then released; then 0xEF, 0xBE, 0xAD, 0xDE → one frame_err pulse, no retrigger while low, then dout=32'hDEADBEEF.
- Two words sent back-to-back with zero idle bits (0x01..0x04 then 0xFF×4) → valid twice; dout=32'h04030201, then 32'hFFFFFFFF.
- rst asserted for 1 cycle mid-way through byte 3, then a full word 0xAABBCCDD → dout=0 after reset, no pulse for the aborted word, then dout=32'hAABBCCDD.
- RX4_TIMEOUT_EN defined, TIMEOUT_CLKS=320:
  - 2 bytes, then 400 idle cycles, then 4 bytes 0x11, 0x22, 0x33, 0x44 → dout=32'h44332211.
  - Repeat the same stimulus without the macro → valid after the 2nd new byte, dout=32'h2211xxxx with the earlier two bytes in the low lanes.
